mem_arb: RTL and testbench
==========================

# mem_arb

Two-to-one memory arbiter that shares one memory bus between the rv32i core's instruction-fetch port and its load/store port. It sits between the core and the single-ported memory/bus slave. It passes strobes through with zero added latency when the bus is free, and locks ownership while a stalled transaction is pending. It routes returning read data to the correct requester and holds it there.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; mask width is DATA_W/8
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- i_addr  in  ADDR_W  fetch address
- i_rstrb  in  1  fetch read request
- i_rdata  out  DATA_W  fetch read data
- i_rbusy  out  1  fetch stall
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_wmask  in  DATA_W/8  byte-enable mask
- d_wstrb, d_rstrb  in  1  store / load request
- d_rdata  out  DATA_W  load data
- d_rbusy, d_wbusy  out  1  load / store stall
- bus_addr, bus_wdata, bus_wmask  out  ADDR_W/DATA_W/DATA_W/8  muxed bus request
- bus_wstrb, bus_rstrb  out  1  bus strobes
- bus_rdata  in  DATA_W  bus read data
- bus_rbusy, bus_wbusy  in  1  bus stalls

## Operation
- Protocol on every port: a request is a strobe level held until it is accepted. A request is accepted at a rising edge where strobe=1 and the matching busy=0. Read data is valid in the cycle after acceptance. Withdrawing a strobe before acceptance is a protocol violation; the arbiter then returns to IDLE and makes no data guarantee.
- d request = d_rstrb | d_wstrb. A simultaneous d_rstrb and d_wstrb is illegal.
- FSM states: IDLE, OWN_I, OWN_D.
  - IDLE: grant is combinational. The picker chooses among current requests. If the granted bus busy is 0, the request is accepted and the FSM stays in IDLE. If busy is 1, go to OWN_x.
  - OWN_x: grant is fixed to x. Go to IDLE on acceptance or when x's strobe drops.
- Granted port: bus_* = port signals. i_rbusy = bus_rbusy. d_rbusy = d_rstrb & bus_rbusy. d_wbusy = d_wstrb & bus_wbusy.
- Non-granted port: busy = its own strobe. Its strobes are not driven to the bus.
- No grant: bus strobes = 0. bus_addr, bus_wdata and bus_wmask = 0.
- Read return: register rsel ∈ {NONE, I, D} is set on a read acceptance and otherwise cleared.
  - x_rdata = bus_rdata when rsel==x, else hold_x.
  - hold_x captures bus_rdata when rsel==x.
  - Writes never set rsel.

## Timing
- Added latency is zero. Strobe to bus is combinational, and bus busy to requester busy is combinational.
- Read data reaches the requester 1 cycle after acceptance, the same as a direct connection.
- Back-to-back accepted requests from alternating ports are allowed on consecutive cycles with no idle cycle.
- Reset values: state=IDLE, rsel=NONE, last=I, hold_i=hold_d=0.
- While rst=0: bus strobes=0, i_rbusy=i_rstrb, d_rbusy=d_rstrb, d_wbusy=d_wstrb, rdata=0.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and any pending ownership is dropped.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. Register `last` records the port of the most recent acceptance. When both ports request in IDLE, the port ≠ last wins.
- MEM_ARB_RR_EN undefined: fixed priority, data port always wins. The `last` register is not built.

## Structure
- Shared package mem_arb_pkg holds:
  - enum for state (IDLE/OWN_I/OWN_D);
  - port-id constants (PORT_NONE/PORT_I/PORT_D) used by both rsel and grant.
- Sub-module mem_arb_pick: a combinational picker.
  - Inputs: i_req, d_req, last.
  - Output: grant id.
  - Holds the MEM_ARB_RR_EN selection.
- The top level contains the FSM, muxes, rsel and the hold registers.

## Test plan
- Lone fetch: i_rstrb=1, i_addr=0x100, bus idle, bus_rdata=0xDEADBEEF in the following cycle. Expect:
  - bus_rstrb=1 and bus_addr=0x100 in the same cycle;
  - i_rdata=0xDEADBEEF in the next cycle, held afterwards.
- Collision, fixed priority: i_rstrb=1 and d_wstrb=1 (d_addr=0x200, d_wdata=0x55, d_wmask=0x1) in the same cycle. Expect:
  - bus_wstrb=1 to 0x200 and i_rbusy=1;
  - fetch accepted in the next cycle.
- Collision with MEM_ARB_RR_EN, last=D: both request. Expect fetch granted first, then store.
- Locked ownership: d_rstrb to 0x300 with bus_rbusy=1 for 3 cycles, and i_rstrb rising in cycle 2. Expect:
  - bus_addr stays 0x300 and i_rbusy=1 throughout;
  - fetch is granted the cycle after the load is accepted.
- Read routing: load returns 0x11, then a fetch returns 0x22. Expect d_rdata to stay 0x11 and i_rdata=0x22.
- Reset mid-lock: rst=0 in OWN_D. Expect:
  - bus strobes 0 immediately;
  - after release, state IDLE and holds 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_arb two-to-one memory arbiter: FSM states and the
// port identifiers used by both the grant and the read-return select.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN_I,
      OWN_D
   } state_e;

   typedef enum logic [1:0] {
      PORT_NONE,
      PORT_I,
      PORT_D
   } port_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational request picker for mem_arb. Round-robin between the fetch and
// data ports when MEM_ARB_RR_EN is defined, otherwise the data port always wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic  i_req,
   input  logic  d_req,
   input  port_e last,
   output port_e grant
);

   port_e both_pick;

`ifdef MEM_ARB_RR_EN
   // On a collision the port that did not win most recently goes first.
   assign both_pick = (last == PORT_D) ? PORT_I : PORT_D;
`else
   logic unused_last;
   assign unused_last = ^last;
   assign both_pick   = PORT_D;
`endif

   // NOTE: grant gets a default before any branch so no latch is inferred.
   always_comb begin
      grant = PORT_NONE;
      if (i_req && d_req) begin
         grant = both_pick;
      end else if (d_req) begin
         grant = PORT_D;
      end else if (i_req) begin
         grant = PORT_I;
      end
   end

endmodule

// File: rtl/mem_arb.sv
// Two-to-one memory arbiter sharing one bus between the fetch and load/store
// ports with zero added latency. Optional round-robin build: MEM_ARB_RR_EN.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic                i_rstrb,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_rbusy,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   input  logic                d_wstrb,
   input  logic                d_rstrb,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_rbusy,
   output logic                d_wbusy,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_wmask,
   output logic                bus_wstrb,
   output logic                bus_rstrb,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_rbusy,
   input  logic                bus_wbusy
);

   state_e            state_q, state_d;
   port_e             rsel_q, rsel_d;
   port_e             grant, pick_grant, pick_last;
   logic [DATA_W-1:0] hold_i_q, hold_i_d, hold_d_q, hold_d_d;
   logic              d_req, acc_i, acc_d;

   assign d_req = d_rstrb | d_wstrb;

   mem_arb_pick u_pick (
      .i_req (i_rstrb),
      .d_req (d_req),
      .last  (pick_last),
      .grant (pick_grant)
   );

`ifdef MEM_ARB_RR_EN
   port_e last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (acc_i) begin
         last_d = PORT_I;
      end else if (acc_d) begin
         last_d = PORT_D;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= PORT_I;
      end else begin
         last_q <= last_d;
      end
   end

   assign pick_last = last_q;
`else
   assign pick_last = PORT_I;
`endif

   // Grant is combinational in IDLE and pinned while a stalled request owns the bus.
   always_comb begin
      state_d = state_q;
      grant   = PORT_NONE;
      case (state_q)
         IDLE:    grant = pick_grant;
         OWN_I:   grant = PORT_I;
         OWN_D:   grant = PORT_D;
         default: grant = PORT_NONE;
      endcase
      if (!rst) begin
         grant = PORT_NONE;
      end

      acc_i = (grant == PORT_I) && i_rstrb && !bus_rbusy;
      acc_d = (grant == PORT_D) && ((d_rstrb && !bus_rbusy) || (d_wstrb && !bus_wbusy));

      case (state_q)
         IDLE: begin
            if (grant == PORT_I && i_rstrb && !acc_i) begin
               state_d = OWN_I;
            end else if (grant == PORT_D && d_req && !acc_d) begin
               state_d = OWN_D;
            end
         end
         OWN_I:   if (acc_i || !i_rstrb) state_d = IDLE;
         OWN_D:   if (acc_d || !d_req)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus_addr  = '0;
      bus_wdata = '0;
      bus_wmask = '0;
      bus_rstrb = 1'b0;
      bus_wstrb = 1'b0;
      i_rbusy   = i_rstrb;
      d_rbusy   = d_rstrb;
      d_wbusy   = d_wstrb;
      case (grant)
         PORT_I: begin
            bus_addr  = i_addr;
            bus_rstrb = i_rstrb;
            i_rbusy   = bus_rbusy;
         end
         PORT_D: begin
            bus_addr  = d_addr;
            bus_wdata = d_wdata;
            bus_wmask = d_wmask;
            bus_rstrb = d_rstrb;
            bus_wstrb = d_wstrb;
            d_rbusy   = d_rstrb & bus_rbusy;
            d_wbusy   = d_wstrb & bus_wbusy;
         end
         default: ;
      endcase
   end

   // Read data is live in the cycle after acceptance and held from then on.
   always_comb begin
      rsel_d = PORT_NONE;
      if (acc_i) begin
         rsel_d = PORT_I;
      end else if (acc_d && d_rstrb) begin
         rsel_d = PORT_D;
      end
      hold_i_d = (rsel_q == PORT_I) ? bus_rdata : hold_i_q;
      hold_d_d = (rsel_q == PORT_D) ? bus_rdata : hold_d_q;
      i_rdata  = (rsel_q == PORT_I) ? bus_rdata : hold_i_q;
      d_rdata  = (rsel_q == PORT_D) ? bus_rdata : hold_d_q;
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the hold registers are reset because the requesters see them straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         rsel_q   <= PORT_NONE;
         hold_i_q <= '0;
         hold_d_q <= '0;
      end else begin
         state_q  <= state_d;
         rsel_q   <= rsel_d;
         hold_i_q <= hold_i_d;
         hold_d_q <= hold_d_d;
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios followed by random traffic
// scored against a word-memory reference model and per-port read queues.
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_addr, d_addr, d_wdata, bus_addr, bus_wdata, bus_rdata;
   logic [31:0] i_rdata, d_rdata;
   logic [3:0]  d_wmask, bus_wmask;
   logic        i_rstrb, i_rbusy, d_wstrb, d_rstrb, d_rbusy, d_wbusy;
   logic        bus_wstrb, bus_rstrb, bus_rbusy, bus_wbusy;

   int n_cmp = 0;
   int n_bad = 0;

   mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_addr    (i_addr),
      .i_rstrb   (i_rstrb),
      .i_rdata   (i_rdata),
      .i_rbusy   (i_rbusy),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wmask   (d_wmask),
      .d_wstrb   (d_wstrb),
      .d_rstrb   (d_rstrb),
      .d_rdata   (d_rdata),
      .d_rbusy   (d_rbusy),
      .d_wbusy   (d_wbusy),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_wmask (bus_wmask),
      .bus_wstrb (bus_wstrb),
      .bus_rstrb (bus_rstrb),
      .bus_rdata (bus_rdata),
      .bus_rbusy (bus_rbusy),
      .bus_wbusy (bus_wbusy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Random-phase state: reference memory, slave memory, expected read queues.
   logic [31:0] ref_mem [16];
   logic [31:0] slv_mem [16];
   logic [31:0] exp_i_q [$];
   logic [31:0] exp_d_q [$];
   logic [31:0] last_i, last_d, slv_wdata;
   logic [3:0]  slv_ridx, slv_widx, slv_wmask;
   bit          rnd_en = 1'b0, quiesce = 1'b0;
   bit          pend_i = 1'b0, pend_d = 1'b0, have_i = 1'b0, have_d = 1'b0;
   bit          i_acc_s = 1'b0, d_acc_s = 1'b0, slv_rd = 1'b0, slv_wr = 1'b0;
   int          i_wait = 0, d_wait = 0, max_wait = 0;

   // Monitor: scores read returns from the queues and bus requests against the accepting port.
   initial begin
      forever begin
         @(negedge clk);
         if (rnd_en) begin
            bit ia, da;
            if (pend_i) begin
               last_i = exp_i_q.pop_front();
               have_i = 1'b1;
               check("i_rdata_return", i_rdata, last_i);
            end else if (have_i) begin
               check("i_rdata_hold", i_rdata, last_i);
            end
            if (pend_d) begin
               last_d = exp_d_q.pop_front();
               have_d = 1'b1;
               check("d_rdata_return", d_rdata, last_d);
            end else if (have_d) begin
               check("d_rdata_hold", d_rdata, last_d);
            end

            ia = i_rstrb && !i_rbusy;
            da = (d_rstrb && !d_rbusy) || (d_wstrb && !d_wbusy);
            check("bus_accept_matches", 32'((bus_rstrb && !bus_rbusy) || (bus_wstrb && !bus_wbusy)),
                  32'(ia || da));
            if (ia) begin
               check("bus_fetch_rstrb", {31'd0, bus_rstrb}, 32'd1);
               check("bus_fetch_addr", bus_addr, i_addr);
               exp_i_q.push_back(ref_mem[i_addr[5:2]]);
            end
            if (da && d_rstrb) begin
               check("bus_load_rstrb", {31'd0, bus_rstrb}, 32'd1);
               check("bus_load_addr", bus_addr, d_addr);
               exp_d_q.push_back(ref_mem[d_addr[5:2]]);
            end
            if (da && d_wstrb) begin
               check("bus_store_wstrb", {31'd0, bus_wstrb}, 32'd1);
               check("bus_store_addr", bus_addr, d_addr);
               check("bus_store_wdata", bus_wdata, d_wdata);
               check("bus_store_wmask", {28'd0, bus_wmask}, {28'd0, d_wmask});
               for (int b = 0; b < 4; b++) begin
                  if (d_wmask[b]) ref_mem[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
               end
            end
            pend_i    = ia;
            pend_d    = da && d_rstrb;
            i_acc_s   = ia;
            d_acc_s   = da;
            slv_rd    = bus_rstrb && !bus_rbusy;
            slv_wr    = bus_wstrb && !bus_wbusy;
            slv_ridx  = bus_addr[5:2];
            slv_widx  = bus_addr[5:2];
            slv_wdata = bus_wdata;
            slv_wmask = bus_wmask;
         end
      end
   end

   task automatic drive_random();
      if (slv_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (slv_wmask[b]) slv_mem[slv_widx][8*b +: 8] = slv_wdata[8*b +: 8];
         end
      end
      bus_rdata = slv_rd ? slv_mem[slv_ridx] : $urandom;
      bus_rbusy = ($urandom_range(0, 3) == 0);
      bus_wbusy = ($urandom_range(0, 3) == 0);

      if (i_rstrb && !i_acc_s) begin
         i_wait++;
      end else begin
         i_wait  = 0;
         i_rstrb = !quiesce && ($urandom_range(0, 1) == 1);
         i_addr  = $urandom & 32'h0000_FFFC;
      end
      if ((d_rstrb || d_wstrb) && !d_acc_s) begin
         d_wait++;
      end else begin
         int op;
         d_wait  = 0;
         op      = quiesce ? 3 : int'($urandom_range(0, 3));
         d_rstrb = (op == 0);
         d_wstrb = (op == 1);
         d_addr  = $urandom & 32'h0000_FFFC;
         d_wdata = $urandom;
         d_wmask = 4'($urandom_range(1, 15));
      end
      if (i_wait > max_wait) max_wait = i_wait;
      if (d_wait > max_wait) max_wait = d_wait;
   endtask

   initial begin
      bit fetch_first;
      rst = 1'b0;
      i_addr = '0; i_rstrb = 1'b0;
      d_addr = '0; d_wdata = '0; d_wmask = '0; d_wstrb = 1'b0; d_rstrb = 1'b0;
      bus_rdata = '0; bus_rbusy = 1'b0; bus_wbusy = 1'b0;

      // Reset: strobes blocked, busy mirrors strobe, read data zero.
      i_rstrb = 1'b1; d_wstrb = 1'b1;
      mid();
      check("rst_bus_rstrb", {31'd0, bus_rstrb}, 32'd0);
      check("rst_bus_wstrb", {31'd0, bus_wstrb}, 32'd0);
      check("rst_i_rbusy", {31'd0, i_rbusy}, 32'd1);
      check("rst_d_wbusy", {31'd0, d_wbusy}, 32'd1);
      check("rst_i_rdata", i_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      tick();
      i_rstrb = 1'b0; d_wstrb = 1'b0; rst = 1'b1;
      tick();

      // Lone fetch.
      i_rstrb = 1'b1; i_addr = 32'h100;
      mid();
      check("fetch_bus_rstrb", {31'd0, bus_rstrb}, 32'd1);
      check("fetch_bus_addr", bus_addr, 32'h100);
      check("fetch_i_rbusy", {31'd0, i_rbusy}, 32'd0);
      tick();
      i_rstrb = 1'b0; bus_rdata = 32'hDEAD_BEEF;
      mid();
      check("fetch_i_rdata", i_rdata, 32'hDEAD_BEEF);
      tick();
      bus_rdata = 32'h1234_5678;
      mid();
      check("fetch_i_rdata_held", i_rdata, 32'hDEAD_BEEF);
      tick();

      // Collision with last=I: the store wins in both builds.
      i_rstrb = 1'b1; i_addr = 32'h104;
      d_wstrb = 1'b1; d_addr = 32'h200; d_wdata = 32'h55; d_wmask = 4'h1;
      mid();
      check("coll_bus_wstrb", {31'd0, bus_wstrb}, 32'd1);
      check("coll_bus_rstrb", {31'd0, bus_rstrb}, 32'd0);
      check("coll_bus_addr", bus_addr, 32'h200);
      check("coll_bus_wdata", bus_wdata, 32'h55);
      check("coll_bus_wmask", {28'd0, bus_wmask}, 32'h1);
      check("coll_i_rbusy", {31'd0, i_rbusy}, 32'd1);
      tick();
      d_wstrb = 1'b0;
      mid();
      check("coll_fetch_next_rstrb", {31'd0, bus_rstrb}, 32'd1);
      check("coll_fetch_next_addr", bus_addr, 32'h104);
      check("coll_fetch_next_rbusy", {31'd0, i_rbusy}, 32'd0);
      tick();
      i_rstrb = 1'b0;

      // Lone store makes last=D, then a collision.
      d_wstrb = 1'b1; d_addr = 32'h204; d_wdata = 32'h77; d_wmask = 4'hF;
      mid();
      check("lone_store_wstrb", {31'd0, bus_wstrb}, 32'd1);
      tick();
      i_rstrb = 1'b1; i_addr = 32'h108;
      d_wstrb = 1'b1; d_addr = 32'h208; d_wdata = 32'h66; d_wmask = 4'h3;
`ifdef MEM_ARB_RR_EN
      fetch_first = 1'b1;
`else
      fetch_first = 1'b0;
`endif
      mid();
      check("coll2_first_addr", bus_addr, fetch_first ? 32'h108 : 32'h208);
      check("coll2_first_rstrb", {31'd0, bus_rstrb}, {31'd0, fetch_first});
      check("coll2_i_rbusy", {31'd0, i_rbusy}, {31'd0, !fetch_first});
      check("coll2_d_wbusy", {31'd0, d_wbusy}, {31'd0, fetch_first});
      tick();
      if (fetch_first) i_rstrb = 1'b0;
      else             d_wstrb = 1'b0;
      mid();
      check("coll2_second_addr", bus_addr, fetch_first ? 32'h208 : 32'h108);
      check("coll2_second_wstrb", {31'd0, bus_wstrb}, {31'd0, fetch_first});
      tick();
      i_rstrb = 1'b0; d_wstrb = 1'b0;
      tick();

      // Locked ownership on a stalled load, then read routing.
      d_rstrb = 1'b1; d_addr = 32'h300; bus_rbusy = 1'b1;
      mid();
      check("lock_c1_addr", bus_addr, 32'h300);
      check("lock_c1_d_rbusy", {31'd0, d_rbusy}, 32'd1);
      tick();
      i_rstrb = 1'b1; i_addr = 32'h400;
      for (int c = 2; c <= 3; c++) begin
         mid();
         check("lock_hold_addr", bus_addr, 32'h300);
         check("lock_hold_i_rbusy", {31'd0, i_rbusy}, 32'd1);
         check("lock_hold_d_rbusy", {31'd0, d_rbusy}, 32'd1);
         tick();
      end
      bus_rbusy = 1'b0;
      mid();
      check("lock_accept_addr", bus_addr, 32'h300);
      check("lock_accept_d_rbusy", {31'd0, d_rbusy}, 32'd0);
      check("lock_accept_i_rbusy", {31'd0, i_rbusy}, 32'd1);
      tick();
      d_rstrb = 1'b0; bus_rdata = 32'h11;
      mid();
      check("after_lock_fetch_addr", bus_addr, 32'h400);
      check("after_lock_fetch_rbusy", {31'd0, i_rbusy}, 32'd0);
      check("route_d_rdata", d_rdata, 32'h11);
      tick();
      i_rstrb = 1'b0; bus_rdata = 32'h22;
      mid();
      check("route_i_rdata", i_rdata, 32'h22);
      check("route_d_rdata_kept", d_rdata, 32'h11);
      tick();
      bus_rdata = 32'h99;
      mid();
      check("route_i_rdata_held", i_rdata, 32'h22);
      check("route_d_rdata_held", d_rdata, 32'h11);
      tick();

      // Reset asserted while the data port owns a stalled load.
      d_rstrb = 1'b1; d_addr = 32'h500; bus_rbusy = 1'b1;
      mid();
      tick();
      mid();
      check("rlock_owned_addr", bus_addr, 32'h500);
      #1 rst = 1'b0;
      #1;
      check("rlock_bus_rstrb", {31'd0, bus_rstrb}, 32'd0);
      check("rlock_d_rbusy", {31'd0, d_rbusy}, 32'd1);
      check("rlock_i_rdata", i_rdata, 32'd0);
      check("rlock_d_rdata", d_rdata, 32'd0);
      tick();
      d_rstrb = 1'b0; bus_rbusy = 1'b0; rst = 1'b1;
      i_rstrb = 1'b1; i_addr = 32'h600;
      mid();
      check("rlock_idle_rstrb", {31'd0, bus_rstrb}, 32'd1);
      check("rlock_idle_addr", bus_addr, 32'h600);
      check("rlock_hold_i", i_rdata, 32'd0);
      check("rlock_hold_d", d_rdata, 32'd0);
      tick();
      i_rstrb = 1'b0;
      tick();

      // Random traffic against the reference model.
      for (int k = 0; k < 16; k++) begin
         ref_mem[k] = $urandom;
         slv_mem[k] = ref_mem[k];
      end
      rnd_en = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         drive_random();
         tick();
      end
      quiesce = 1'b1;
      for (int n = 0; n < 200; n++) begin
         drive_random();
         tick();
      end
      mid();
      rnd_en = 1'b0;
      check("scoreboard_drained", 32'(exp_i_q.size() + exp_d_q.size()), 32'd0);
      check("requests_not_starved", 32'(max_wait <= 200), 32'd1);
      check("requesters_idle", {30'd0, i_rstrb, d_rstrb | d_wstrb}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
